// File: rtl/npc_clint_axi_slave.sv
// npc_clint_axi_slave
// Core-local timer (CLINT mtime) behind the core's AXI4 master port.
// mtime is read-only: reads return a 64-bit snapshot captured at AR
// acceptance, so both halves of a two-beat read are consistent. Writes
// are drained and answered with SLVERR.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   s_aw* / s_w* / s_b*   AXI4 write channels (data discarded, bresp=SLVERR)
//   s_ar* / s_r*          AXI4 read channels (mtime window at BASE_ADDR)
//   mtime                 live timer value for interrupt logic
//
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for AR, s_arready high
//   R_DATA | presenting beats of the latched burst
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for AW, s_awready high
//   W_DATA | draining W beats until wlast
//   W_RESP | holding SLVERR B response until bready
module npc_clint_axi_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned ID_W      = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [31:0]     s_awaddr,
  input  logic [ID_W-1:0] s_awid,
  input  logic [7:0]      s_awlen,
  input  logic            s_wvalid,
  output logic            s_wready,
  input  logic [31:0]     s_wdata,
  input  logic [3:0]      s_wstrb,
  input  logic            s_wlast,
  output logic            s_bvalid,
  input  logic            s_bready,
  output logic [1:0]      s_bresp,
  output logic [ID_W-1:0] s_bid,
  input  logic            s_arvalid,
  output logic            s_arready,
  input  logic [31:0]     s_araddr,
  input  logic [ID_W-1:0] s_arid,
  input  logic [7:0]      s_arlen,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [31:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic [ID_W-1:0] s_rid,
  output logic            s_rlast,
  output logic [63:0]     mtime
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Write address/data content is intentionally ignored.
  wire w_unused = ^{s_awaddr, s_awlen, s_wdata, s_wstrb};

  // ---------------------------------------------------------------- timer
  logic [PS_W-1:0] r_prescale;
  logic [63:0]     r_mtime;
  wire             w_tick = (r_prescale == PS_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prescale <= '0;
      r_mtime    <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
      r_mtime    <= r_mtime + 64'd1;
    end else begin
      r_prescale <= r_prescale + PS_W'(1);
    end
  end

  assign mtime = r_mtime;

  // ------------------------------------------------------------ read path
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  rstate_t         r_rstate;
  rstate_t         w_rstate_nxt;
  logic [31:0]     r_raddr;
  logic [ID_W-1:0] r_rid;
  logic [7:0]      r_rlen;
  logic [7:0]      r_rbeat;
  logic [63:0]     r_snap;

  wire w_ar_hs = s_arvalid && s_arready;
  wire w_r_hs  = s_rvalid && s_rready;

  // Every beat is range/alignment checked on its own address, so a burst
  // may straddle the window edge and mix OKAY and SLVERR beats.
  wire [31:0] w_beat_addr = r_raddr + {22'd0, r_rbeat, 2'b00};
  wire [31:0] w_beat_off  = w_beat_addr - BASE_ADDR;
  wire        w_beat_ok   = (w_beat_off < 32'd8) && (w_beat_addr[1:0] == 2'b00);
  wire        w_beat_last = (r_rbeat == r_rlen);

  always_ff @(posedge clock) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_raddr <= '0;
      r_rid   <= '0;
      r_rlen  <= '0;
      r_rbeat <= '0;
      r_snap  <= '0;
    end else if (w_ar_hs) begin
      r_raddr <= s_araddr;
      r_rid   <= s_arid;
      r_rlen  <= s_arlen;
      r_rbeat <= '0;
      r_snap  <= r_mtime;
    end else if (w_r_hs && !w_beat_last) begin
      r_rbeat <= r_rbeat + 8'd1;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    s_rdata      = '0;
    s_rresp      = 2'b00;
    s_rid        = '0;
    s_rlast      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        s_arready = !reset;
        if (s_arvalid && !reset) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        s_rid    = r_rid;
        s_rlast  = w_beat_last;
        if (w_beat_ok) begin
          s_rdata = w_beat_off[2] ? r_snap[63:32] : r_snap[31:0];
          s_rresp = 2'b00;
        end else begin
          s_rdata = '0;
          s_rresp = 2'b10;
        end
        if (s_rready && w_beat_last) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // ----------------------------------------------------------- write path
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  wstate_t         r_wstate;
  wstate_t         w_wstate_nxt;
  logic [ID_W-1:0] r_awid;

  wire w_aw_hs = s_awvalid && s_awready;

  always_ff @(posedge clock) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset)        r_awid <= '0;
    else if (w_aw_hs) r_awid <= s_awid;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_bvalid     = 1'b0;
    s_bresp      = 2'b00;
    s_bid        = '0;
    case (r_wstate)
      W_IDLE: begin
        s_awready = !reset;
        if (s_awvalid && !reset) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = 2'b10;
        s_bid    = r_awid;
        if (s_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

endmodule
